bram_bist_fsm: RTL and testbench

//  Parametrised built-in self-test sequencer for the dual-port block RAM. Drives both ports
//  (data/addr/we) through a 4-phase write/verify/write-inverse/verify sweep. Checks read-back

---
 rtl/bram_bist_pkg.sv | 18 +
 rtl/bram_bist_fsm_if.sv | 20 ++
 rtl/bram_bist_pattern.sv | 33 +++
 rtl/bram_bist_fsm.sv | 176 +++++++++++++++++
 tb/tb_bram_bist_fsm.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_bist_pkg.sv
// Shared types and constants for the dual-port BRAM self-test sequencer.
package bram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    WR1  = 3'd3,
    RD1  = 3'd4,
    DONE = 3'd5
  } bist_state_e;

  localparam logic [1:0] MODE_ADDR = 2'd0;
  localparam logic [1:0] MODE_CHK  = 2'd1;
  localparam logic [1:0] MODE_ONES = 2'd2;
  localparam logic [1:0] MODE_WALK = 2'd3;

endpackage

// File: rtl/bram_bist_fsm_if.sv
// Dual-port BRAM bus as seen by the self-test sequencer (master) and the RAM (slave).
interface bram_bist_fsm_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] data_a, data_b;
  logic [DATA_WIDTH-1:0] q_a, q_b;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic                  we_a, we_b;

  modport master (
    output data_a, data_b, addr_a, addr_b, we_a, we_b,
    input  q_a, q_b
  );

  modport slave (
    input  data_a, data_b, addr_a, addr_b, we_a, we_b,
    output q_a, q_b
  );
endinterface

// File: rtl/bram_bist_pattern.sv
// Test pattern generator: P(addr) for the selected mode, optionally inverted.
module bram_bist_pattern
  import bram_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            mode,
  input  logic                  inv,
  output logic [DATA_WIDTH-1:0] pat
);

  logic [DATA_WIDTH-1:0] chk;

  // Even addresses get ...0101, odd addresses ...1010.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_chk
    assign chk[i] = addr[0] ^ ((i % 2) == 0);
  end

  always_comb begin
    pat = '0;
    case (mode)
      MODE_ADDR: pat = DATA_WIDTH'(addr);
      MODE_CHK:  pat = chk;
      MODE_ONES: pat = '1;
      MODE_WALK: pat = DATA_WIDTH'(1) << (addr % DATA_WIDTH);
      default:   pat = '0;
    endcase
    if (inv) pat = ~pat;
  end

endmodule

// File: rtl/bram_bist_fsm.sv
// Dual-port BRAM self-test: write / verify / write-inverse / verify sweep with
// port A on even and port B on odd addresses, saturating error count and first fail address.
module bram_bist_fsm
  import bram_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 1,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  bram_bist_fsm_if.master       ram,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  localparam int              KW       = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
  localparam logic [KW-1:0]   IDX_LAST = KW'((2 ** (ADDR_WIDTH - 1)) - 1);
  localparam logic [1:0]      DRN_LAST = 2'(RD_LAT - 1);

  typedef struct packed {
    logic [KW-1:0]         idx;
    logic [DATA_WIDTH-1:0] exp_a;
    logic [DATA_WIDTH-1:0] exp_b;
  } rd_ent_t;

  bist_state_e           state, state_d;
  logic [KW-1:0]         idx, idx_d;
  logic                  drain, drain_d;
  logic [1:0]            dcnt, dcnt_d;
  logic [1:0]            mode_q;
  logic                  wr, act, inv, rd_issue;
  logic [ADDR_WIDTH-1:0] a_a, a_b;
  logic [DATA_WIDTH-1:0] pat_a, pat_b;
  logic                  pass_q;

  logic [RD_LAT:1]       vld_pipe;
  rd_ent_t               ent_pipe [1:RD_LAT];
  rd_ent_t               tail;
  logic                  mis_a, mis_b;
  logic [ERR_WIDTH:0]    err_sum;
  logic [ERR_WIDTH-1:0]  err_nxt;

  assign a_a = ADDR_WIDTH'({idx, 1'b0});
  assign a_b = ADDR_WIDTH'({idx, 1'b1});

  bram_bist_pattern #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_a (
    .addr(a_a), .mode(mode_q), .inv(inv), .pat(pat_a)
  );
  bram_bist_pattern #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_b (
    .addr(a_b), .mode(mode_q), .inv(inv), .pat(pat_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      drain <= 1'b0;
      dcnt  <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      drain <= drain_d;
      dcnt  <= dcnt_d;
    end
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    drain_d  = drain;
    dcnt_d   = dcnt;
    wr       = 1'b0;
    act      = 1'b0;
    inv      = 1'b0;
    rd_issue = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_d = WR0;
        idx_d   = '0;
      end
      WR0, WR1: begin
        wr  = 1'b1;
        act = 1'b1;
        inv = (state == WR1);
        if (idx == IDX_LAST) begin
          idx_d   = '0;
          state_d = (state == WR0) ? RD0 : RD1;
        end else begin
          idx_d = idx + 1'b1;
        end
      end
      RD0, RD1: begin
        act = 1'b1;
        inv = (state == RD1);
        if (!drain) begin
          rd_issue = 1'b1;
          if (idx == IDX_LAST) begin
            drain_d = 1'b1;
            dcnt_d  = '0;
          end else begin
            idx_d = idx + 1'b1;
          end
        // Drain: address holds while the last reads come back.
        end else if (dcnt == DRN_LAST) begin
          drain_d = 1'b0;
          idx_d   = '0;
          state_d = (state == RD0) ? WR1 : DONE;
        end else begin
          dcnt_d = dcnt + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign ram.we_a   = wr;
  assign ram.we_b   = wr;
  assign ram.addr_a = act ? a_a : '0;
  assign ram.addr_b = act ? a_b : '0;
  assign ram.data_a = wr ? pat_a : '0;
  assign ram.data_b = wr ? pat_b : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_issue;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    ent_pipe[1] <= '{idx: idx, exp_a: pat_a, exp_b: pat_b};
    for (int i = 2; i <= RD_LAT; i++) ent_pipe[i] <= ent_pipe[i-1];
  end

  assign tail    = ent_pipe[RD_LAT];
  assign mis_a   = vld_pipe[RD_LAT] && (ram.q_a != tail.exp_a);
  assign mis_b   = vld_pipe[RD_LAT] && (ram.q_b != tail.exp_b);
  assign err_sum = {1'b0, err_count} + (ERR_WIDTH + 1)'(mis_a) + (ERR_WIDTH + 1)'(mis_b);
  assign err_nxt = err_sum[ERR_WIDTH] ? '1 : err_sum[ERR_WIDTH-1:0];

  // Count is monotonic within a test, so zero means no mismatch seen yet.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
      fail_addr <= '0;
      pass_q    <= 1'b0;
      mode_q    <= MODE_ADDR;
    end else if (state == IDLE && start) begin
      err_count <= '0;
      fail_addr <= '0;
      pass_q    <= 1'b0;
      mode_q    <= mode;
    end else begin
      if (mis_a || mis_b) begin
        err_count <= err_nxt;
        if (err_count == '0) fail_addr <= ADDR_WIDTH'({tail.idx, ~mis_a});
      end
      if (state == DONE) pass_q <= (err_count == '0);
    end
  end

  assign pass = done ? (err_count == '0) : pass_q;

endmodule

// File: tb/tb_bram_bist_fsm.sv
// Scoreboard bench: three sequencer instances (RD_LAT 1/3, ERR_WIDTH 8/2) against a fault-injectable BRAM model.
module tb_bram_bist_fsm;

  typedef struct {
    int cycles;
    bit pass;
    int err;
    int fail;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  logic start0, start1, start2;
  logic [1:0] mode0, mode1, mode2;
  logic busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic [3:0] fail0, fail1, fail2;

  always #5 clk = ~clk;

  bram_bist_fsm_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) b0 ();
  bram_bist_fsm_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) b1 ();
  bram_bist_fsm_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) b2 ();

  bram_bist_fsm #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LAT(1), .ERR_WIDTH(8)) u0 (
    .clk(clk), .reset(reset), .start(start0), .mode(mode0), .ram(b0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_addr(fail0));
  bram_bist_fsm #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LAT(3), .ERR_WIDTH(8)) u1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode1), .ram(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_addr(fail1));
  bram_bist_fsm #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LAT(1), .ERR_WIDTH(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .mode(mode2), .ram(b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_addr(fail2));

  // BRAM models; reads see stuck-at-1 (set_m) / stuck-at-0 (clr_m) faults.
  logic [15:0] mem0 [16] = '{default: 16'h0};
  logic [15:0] mem1 [16] = '{default: 16'h0};
  logic [15:0] mem2 [16] = '{default: 16'h0};
  logic [15:0] set_m [16];
  logic [15:0] clr_m [16];
  bit          wdis;
  logic [15:0] q0a, q0b;
  logic [15:0] q1a [3];
  logic [15:0] q1b [3];
  logic [15:0] q2a, q2b;

  function automatic logic [15:0] rdm(input logic [15:0] w, input logic [3:0] a);
    return (w & ~clr_m[a]) | set_m[a];
  endfunction

  always @(posedge clk) begin
    if (b0.we_a && !wdis) mem0[b0.addr_a] <= b0.data_a;
    if (b0.we_b && !wdis) mem0[b0.addr_b] <= b0.data_b;
    q0a <= rdm(mem0[b0.addr_a], b0.addr_a);
    q0b <= rdm(mem0[b0.addr_b], b0.addr_b);
  end
  assign b0.q_a = q0a;
  assign b0.q_b = q0b;

  always @(posedge clk) begin
    if (b1.we_a && !wdis) mem1[b1.addr_a] <= b1.data_a;
    if (b1.we_b && !wdis) mem1[b1.addr_b] <= b1.data_b;
    q1a[0] <= rdm(mem1[b1.addr_a], b1.addr_a);
    q1b[0] <= rdm(mem1[b1.addr_b], b1.addr_b);
    q1a[1] <= q1a[0];
    q1b[1] <= q1b[0];
    q1a[2] <= q1a[1];
    q1b[2] <= q1b[1];
  end
  assign b1.q_a = q1a[2];
  assign b1.q_b = q1b[2];

  always @(posedge clk) begin
    if (b2.we_a && !wdis) mem2[b2.addr_a] <= b2.data_a;
    if (b2.we_b && !wdis) mem2[b2.addr_b] <= b2.data_b;
    q2a <= rdm(mem2[b2.addr_a], b2.addr_a);
    q2b <= rdm(mem2[b2.addr_b], b2.addr_b);
  end
  assign b2.q_a = q2a;
  assign b2.q_b = q2b;

  // Observed signals of the instance under test.
  int cur;
  logic m_busy, m_done, m_pass;
  logic [7:0] m_err;
  logic [3:0] m_fail;
  always_comb begin
    m_busy = busy0; m_done = done0; m_pass = pass0; m_err = err0; m_fail = fail0;
    case (cur)
      1: begin m_busy = busy1; m_done = done1; m_pass = pass1; m_err = err1; m_fail = fail1; end
      2: begin m_busy = busy2; m_done = done2; m_pass = pass2; m_err = {6'd0, err2}; m_fail = fail2; end
      default: ;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;
  int spur  = 0;
  bit wr_chk = 1'b0;
  res_t res_q [$];
  logic [39:0] wq [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int a, input int mode);
    logic [15:0] one = 16'h1;
    case (mode)
      0:       return 16'(a);
      1:       return (a % 2 == 0) ? 16'h5555 : 16'hAAAA;
      2:       return 16'hFFFF;
      default: return one << (a % 16);
    endcase
  endfunction

  // Reads are checked in issue order: pair k at a time, port A before port B.
  function automatic res_t model(input int mode, input int lat, input int errw, input bit nowr);
    res_t r;
    int   emax = (1 << errw) - 1;
    bit   seen = 1'b0;
    logic [15:0] e, w, q;
    r.err = 0; r.fail = 0;
    for (int ph = 0; ph < 2; ph++)
      for (int a = 0; a < 16; a++) begin
        e = pat(a, mode) ^ (ph == 1 ? 16'hFFFF : 16'h0);
        w = nowr ? 16'h0 : e;
        q = rdm(w, 4'(a));
        if (q != e) begin
          if (!seen) r.fail = a;
          seen = 1'b1;
          if (r.err < emax) r.err++;
        end
      end
    r.pass   = !seen;
    r.cycles = 2 * 8 + 2 * (8 + lat) + 1;
    return r;
  endfunction

  // Monitor: cycles counted from the first busy cycle (the cycle after start).
  initial begin
    int   cnt = 0;
    res_t r;
    forever begin
      @(negedge clk);
      if (reset || !m_busy) cnt = 0;
      else cnt++;
      if (m_done) begin
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          chk("cycles", 64'(cnt), 64'(r.cycles));
          chk("pass", m_pass, r.pass);
          chk("err_count", m_err, 64'(r.err));
          chk("fail_addr", m_fail, 64'(r.fail));
        end else spur++;
      end
      if (cur == 0 && wr_chk && b0.we_a) begin
        if (wq.size() > 0) chk("write", {b0.addr_a, b0.data_a, b0.addr_b, b0.data_b}, wq.pop_front());
        else spur++;
      end
      if (cur == 0 && busy0 && !b0.we_a) chk("rd_data", {b0.data_a, b0.data_b}, 0);
    end
  end

  task automatic pulse(input int inst, input logic [1:0] mode);
    @(negedge clk);
    case (inst)
      0: begin start0 = 1'b1; mode0 = mode; end
      1: begin start1 = 1'b1; mode1 = mode; end
      default: begin start2 = 1'b1; mode2 = mode; end
    endcase
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic run(input int inst, input int mode, input bit repulse);
    res_t r;
    int lat  = (inst == 1) ? 3 : 1;
    int errw = (inst == 2) ? 2 : 8;
    cur = inst;
    r = model(mode, lat, errw, wdis);
    res_q.push_back(r);
    if (wr_chk)
      for (int ph = 0; ph < 2; ph++)
        for (int k = 0; k < 8; k++)
          wq.push_back({4'(2*k), pat(2*k, mode) ^ (ph == 1 ? 16'hFFFF : 16'h0),
                        4'(2*k+1), pat(2*k+1, mode) ^ (ph == 1 ? 16'hFFFF : 16'h0)});
    pulse(inst, 2'(mode));
    if (repulse) begin
      repeat (10) @(negedge clk);
      pulse(inst, 2'(mode + 1));
    end
    for (int i = 0; i < 200 && res_q.size() != 0; i++) @(negedge clk);
    if (res_q.size() != 0) begin
      chk("done_timeout", 64'(res_q.size()), 0);
      res_q.delete();
    end
    @(negedge clk);
    chk("pass_hold", m_pass, r.pass);
    chk("busy_after", m_busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    mode0 = 2'd0; mode1 = 2'd0; mode2 = 2'd0;
    cur = 0; wdis = 1'b0;
    for (int i = 0; i < 16; i++) begin set_m[i] = 16'h0; clr_m[i] = 16'h0; end
    repeat (3) @(negedge clk);
    chk("rst_busy", {busy0, busy1, busy2}, 0);
    chk("rst_done", {done0, done1, done2}, 0);
    chk("rst_pass", {pass0, pass1, pass2}, 0);
    chk("rst_err", {err0, err1, err2}, 0);
    chk("rst_fail", {fail0, fail1, fail2}, 0);
    chk("rst_we", {b0.we_a, b0.we_b, b1.we_a, b1.we_b, b2.we_a, b2.we_b}, 0);
    chk("rst_addr", {b0.addr_a, b0.addr_b, b1.addr_a, b1.addr_b}, 0);
    chk("rst_data", {b0.data_a, b0.data_b, b1.data_a}, 0);
    reset = 1'b0;

    // Good RAM, address-as-data, write stream checked.
    wr_chk = 1'b1;
    run(0, 0, 1'b0);
    wr_chk = 1'b0;
    chk("writes_left", 64'(wq.size()), 0);

    // Stuck-at-1 bit 0 at address 5, checkerboard.
    set_m[5] = 16'h0001;
    run(0, 1, 1'b0);
    set_m[5] = 16'h0;

    // Addresses 6 and 7 both fail in the same read cycle.
    clr_m[6] = 16'h0001; clr_m[7] = 16'h0001;
    run(0, 2, 1'b0);
    clr_m[6] = 16'h0; clr_m[7] = 16'h0;

    // Reset during RD0: aborts without done, then a clean walking-one test.
    cur = 0;
    pulse(0, 2'd0);
    repeat (11) @(negedge clk);
    chk("rd0_busy", busy0, 1);
    chk("rd0_we", {b0.we_a, b0.we_b}, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_we", {b0.we_a, b0.we_b}, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_pass", pass0, 0);
    spur = 0;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(spur), 0);
    wr_chk = 1'b1;
    run(0, 3, 1'b0);
    wr_chk = 1'b0;
    chk("writes_left2", 64'(wq.size()), 0);

    // RD_LAT=3 with a start re-pulse mid-test.
    run(1, 1, 1'b1);

    // ERR_WIDTH=2, RAM that never takes writes, all-ones.
    wdis = 1'b1;
    run(2, 2, 1'b0);
    wdis = 1'b0;

    chk("spurious_events", 64'(spur), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
